// File: rtl/ifmap_rw_pkg.sv
// Shared definitions for the ifmap buffer read/write paths.
// Holds the cfg labels and the read-side FSM encodings.
package ifmap_rw_pkg;

    localparam int RDFSM_WIDTH = 3;

    typedef enum logic [1:0] {
        CFG_NONE = 2'd0,
        NORMAL   = 2'd1,
        LEFT     = 2'd2,
        RIGH     = 2'd3
    } cfg_e;

    typedef enum logic [RDFSM_WIDTH-1:0] {
        RD_IDLE   = 3'd0,
        RD_NORMAL = 3'd1,
        RD_LEFT   = 3'd2,
        RD_RIGH   = 3'd3,
        RD_DONE   = 3'd4
    } rd_state_e;

endpackage

// File: rtl/ifr_cnt_fsm_rd_count.sv
// Wrap counter: counts 0..final_number, then returns to 0.
// clear has priority over enable.
module rd_count #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] final_number,
    output logic             last,
    output logic [WIDTH-1:0] total_q
);

    assign last = (total_q == final_number);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
        end else if (clear) begin
            total_q <= '0;
        end else if (enable) begin
            total_q <= last ? '0 : total_q + 1'b1;
        end
    end

endmodule

// File: rtl/ifr_cnt_fsm.sv
// Ifmap buffer read side: SRAM address generation and pad insertion.
// Beat-side flags are realigned to the 1-cycle SRAM read latency.
module ifr_cnt_fsm
    import ifmap_rw_pkg::*;
#(
    parameter int CNT00_WIDTH   = 10,
    parameter int CNT01_WIDTH   = 10,
    parameter int CNT02_WIDTH   = 10,
    parameter int RS_ADDR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din_start,
    input  logic [1:0]               din_cfg_mast_state,
    input  logic                     rd_en,
    input  logic [CNT00_WIDTH-1:0]   rd_cnt00_finalnum,
    input  logic [CNT01_WIDTH-1:0]   rd_cnt01_finalnum,
    input  logic [CNT02_WIDTH-1:0]   rd_cnt02_finalnum,
    input  logic [RS_ADDR_WIDTH-1:0] rd_srad_finalnum,
    output logic [RDFSM_WIDTH-1:0]   dout_rd_curr_state,
    output logic [RS_ADDR_WIDTH-1:0] dout_rd_srad,
    output logic                     dout_rd_sram_en,
    output logic                     dout_rd_valid,
    output logic                     dout_rd_pad,
    output logic                     dout_rd_row_last,
    output logic                     dout_rd_done
);

    rd_state_e state, nxt;
    cfg_e      cfg_q;

    logic start_acc;
    logic in_norm, in_left, in_righ;
    logic beat, row_end;
    logic c00_last, c01_last, c02_last, srad_last;

    logic [CNT00_WIDTH-1:0] c00_q;
    logic [CNT01_WIDTH-1:0] c01_q;
    logic [CNT02_WIDTH-1:0] c02_q;

    assign start_acc = (state == RD_IDLE) && din_start;
    assign in_norm   = (state == RD_NORMAL);
    assign in_left   = (state == RD_LEFT);
    assign in_righ   = (state == RD_RIGH);
    assign beat      = rd_en && (in_norm || in_left || in_righ);

    // A row ends on the last pad beat under RIGH, else on the last read beat.
    assign row_end = beat && c00_last &&
                     ((in_norm && c01_last && (cfg_q != RIGH)) || in_righ);

    rd_count #(.WIDTH(CNT00_WIDTH)) u_cnt00 (
        .clk          (clk),
        .reset        (reset),
        .enable       (beat),
        .clear        (start_acc),
        .final_number (rd_cnt00_finalnum),
        .last         (c00_last),
        .total_q      (c00_q)
    );

    rd_count #(.WIDTH(CNT01_WIDTH)) u_cnt01 (
        .clk          (clk),
        .reset        (reset),
        .enable       (beat && in_norm && c00_last),
        .clear        (start_acc),
        .final_number (rd_cnt01_finalnum),
        .last         (c01_last),
        .total_q      (c01_q)
    );

    rd_count #(.WIDTH(CNT02_WIDTH)) u_cnt02 (
        .clk          (clk),
        .reset        (reset),
        .enable       (row_end),
        .clear        (start_acc),
        .final_number (rd_cnt02_finalnum),
        .last         (c02_last),
        .total_q      (c02_q)
    );

    rd_count #(.WIDTH(RS_ADDR_WIDTH)) u_srad (
        .clk          (clk),
        .reset        (reset),
        .enable       (beat && in_norm),
        .clear        (start_acc),
        .final_number (rd_srad_finalnum),
        .last         (srad_last),
        .total_q      (dout_rd_srad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RD_IDLE;
            cfg_q <= CFG_NONE;
        end else begin
            state <= nxt;
            if (start_acc) begin
                cfg_q <= cfg_e'(din_cfg_mast_state);
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            RD_IDLE: begin
                if (din_start) begin
                    nxt = (cfg_e'(din_cfg_mast_state) == LEFT) ?
                          RD_LEFT : RD_NORMAL;
                end
            end
            RD_LEFT: begin
                if (beat && c00_last) begin
                    nxt = RD_NORMAL;
                end
            end
            RD_NORMAL: begin
                if (beat && c00_last && c01_last) begin
                    if (cfg_q == RIGH) begin
                        nxt = RD_RIGH;
                    end else if (c02_last) begin
                        nxt = RD_DONE;
                    end else if (cfg_q == LEFT) begin
                        nxt = RD_LEFT;
                    end else begin
                        nxt = RD_NORMAL;
                    end
                end
            end
            RD_RIGH: begin
                if (beat && c00_last) begin
                    nxt = c02_last ? RD_DONE : RD_NORMAL;
                end
            end
            RD_DONE: nxt = RD_IDLE;
            default: nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_rd_valid    <= 1'b0;
            dout_rd_pad      <= 1'b0;
            dout_rd_row_last <= 1'b0;
        end else begin
            dout_rd_valid    <= beat;
            dout_rd_pad      <= beat && (in_left || in_righ);
            dout_rd_row_last <= row_end;
        end
    end

    assign dout_rd_curr_state = state;
    assign dout_rd_sram_en    = beat && in_norm;
    assign dout_rd_done       = (state == RD_DONE);

endmodule

// File: tb/tb_ifr_cnt_fsm.sv
// Scoreboard bench for ifr_cnt_fsm: expected beats and addresses are
// queued at frame issue and popped by a negedge monitor.
module tb_ifr_cnt_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din_start = 1'b0;
    logic [1:0] din_cfg_mast_state = 2'd0;
    logic       rd_en = 1'b0;
    logic [9:0] f0 = 10'd1;
    logic [9:0] f1 = 10'd2;
    logic [9:0] f2 = 10'd1;
    logic [9:0] sf = 10'd1023;

    logic [2:0] st;
    logic [9:0] srad;
    logic       sram_en, valid, pad, row_last, done;

    ifr_cnt_fsm dut (
        .clk                (clk),
        .reset              (reset),
        .din_start          (din_start),
        .din_cfg_mast_state (din_cfg_mast_state),
        .rd_en              (rd_en),
        .rd_cnt00_finalnum  (f0),
        .rd_cnt01_finalnum  (f1),
        .rd_cnt02_finalnum  (f2),
        .rd_srad_finalnum   (sf),
        .dout_rd_curr_state (st),
        .dout_rd_srad       (srad),
        .dout_rd_sram_en    (sram_en),
        .dout_rd_valid      (valid),
        .dout_rd_pad        (pad),
        .dout_rd_row_last   (row_last),
        .dout_rd_done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] beat_q[$];
    int         addr_q[$];
    int         st_log[$];
    int         done_cnt = 0;
    bit         done_seen = 1'b0;
    bit         sb_en = 1'b0;
    logic [2:0] prev_st = 3'd0;
    logic [9:0] prev_srad = 10'd0;
    logic       prev_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model of one frame: beat flags {pad,row_last} and addresses.
    task automatic push_frame(input int cfg);
        int a;
        a = 0;
        for (int r = 0; r <= int'(f2); r++) begin
            if (cfg == 2) begin
                for (int k = 0; k <= int'(f0); k++) beat_q.push_back(2'b10);
            end
            for (int p = 0; p <= int'(f1); p++) begin
                for (int w = 0; w <= int'(f0); w++) begin
                    addr_q.push_back(a);
                    a = (a == int'(sf)) ? 0 : a + 1;
                    beat_q.push_back({1'b0, (cfg != 3) && (p == int'(f1))
                                             && (w == int'(f0))});
                end
            end
            if (cfg == 3) begin
                for (int k = 0; k <= int'(f0); k++)
                    beat_q.push_back({1'b1, k == int'(f0)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (sb_en) begin
            if (sram_en) begin
                if (addr_q.size() == 0) chk("extra_read", 1, 0);
                else chk("srad", int'(srad), addr_q.pop_front());
            end
            if (valid) begin
                if (beat_q.size() == 0) chk("extra_beat", 1, 0);
                else chk("pad_last", int'({pad, row_last}),
                         int'(beat_q.pop_front()));
            end
            if (done) begin
                chk("done_align", int'({valid, row_last}), 3);
                chk("done_q_empty", beat_q.size(), 0);
                done_seen = 1'b1;
            end
            if (st != prev_st) st_log.push_back(int'(st));
            if (!prev_en && prev_st inside {3'd1, 3'd2, 3'd3}) begin
                chk("stall_srad", int'(srad), int'(prev_srad));
                chk("stall_state", int'(st), int'(prev_st));
            end
        end
        prev_st   = st;
        prev_srad = srad;
        prev_en   = rd_en;
    end

    task automatic run_frame(input int cfg, input bit tog,
                             input int exp_st[$]);
        int d0;
        int k;
        push_frame(cfg);
        st_log.delete();
        done_seen = 1'b0;
        d0 = done_cnt;
        @(posedge clk); #1;
        din_start = 1'b1;
        din_cfg_mast_state = cfg[1:0];
        @(posedge clk); #1;
        din_start = 1'b0;
        din_cfg_mast_state = 2'd0;
        rd_en = 1'b1;
        k = 0;
        while (!done_seen && k < 500) begin
            @(posedge clk); #1;
            rd_en = tog ? ~rd_en : 1'b1;
            k++;
        end
        rd_en = 1'b0;
        if (!done_seen) chk("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("beat_q_drained", beat_q.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("state_seq_len", st_log.size(), exp_st.size());
        for (int i = 0; i < exp_st.size() && i < st_log.size(); i++)
            chk("state_seq", st_log[i], exp_st[i]);
        beat_q.delete();
        addr_q.delete();
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(st), 0);
        chk("rst_srad", int'(srad), 0);
        chk("rst_sram_en", int'(sram_en), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_pad_last", int'({pad, row_last}), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        sb_en = 1'b1;

        run_frame(1, 1'b0, '{1, 4, 0});
        run_frame(2, 1'b0, '{2, 1, 2, 1, 4, 0});
        run_frame(3, 1'b0, '{1, 3, 1, 3, 4, 0});
        run_frame(3, 1'b1, '{1, 3, 1, 3, 4, 0});
        sf = 10'd4;
        run_frame(1, 1'b0, '{1, 4, 0});
        run_frame(1, 1'b1, '{1, 4, 0});
        sf = 10'd1023;

        // Reset in the middle of a NORMAL row.
        sb_en = 1'b0;
        @(posedge clk); #1;
        din_start = 1'b1;
        din_cfg_mast_state = 2'd1;
        @(posedge clk); #1;
        din_start = 1'b0;
        rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("mid_rst_state", int'(st), 0);
        chk("mid_rst_srad", int'(srad), 0);
        chk("mid_rst_sram_en", int'(sram_en), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_pad_last", int'({pad, row_last}), 0);
        repeat (3) @(posedge clk);
        #1;
        rd_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        sb_en = 1'b1;
        run_frame(1, 1'b0, '{1, 4, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
